// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO of {vaddr, inst} between fetch and decode.
// Define IB_BYPASS_EN to forward an offered entry straight to decode when the buffer is empty.
module inst_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [31:0]              inst_i,
    input  logic [31:0]              vaddr_i,
    input  logic                     ib_valid_i,
    output logic                     ib_ready_o,
    output logic [31:0]              inst_o,
    output logic [31:0]              vaddr_o,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   inst_q  [DEPTH];
    logic [31:0]   vaddr_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    assign ib_ready_o = count_q != FULL;
    assign count_o    = count_q;

`ifdef IB_BYPASS_EN
    logic byp;
    assign byp        = count_q == '0 && ib_valid_i && !flush;
    assign id_valid_o = !flush && (count_q != '0 || byp);
    assign inst_o     = byp ? inst_i  : inst_q[rd_ptr_q];
    assign vaddr_o    = byp ? vaddr_i : vaddr_q[rd_ptr_q];
    // A bypassed entry taken by decode is never written
    assign push       = ib_valid_i && ib_ready_o && !flush && !(byp && id_ready_i);
    assign pop        = id_valid_o && id_ready_i && !flush && !byp;
`else
    assign id_valid_o = !flush && count_q != '0;
    assign inst_o     = inst_q[rd_ptr_q];
    assign vaddr_o    = vaddr_q[rd_ptr_q];
    assign push       = ib_valid_i && ib_ready_o && !flush;
    assign pop        = id_valid_o && id_ready_i && !flush;
`endif

    always_comb begin
        wr_ptr_d = flush ? '0 : (push ? wr_ptr_q + 1'b1 : wr_ptr_q);
        rd_ptr_d = flush ? '0 : (pop  ? rd_ptr_q + 1'b1 : rd_ptr_q);
        count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr_q]  <= inst_i;
            vaddr_q[wr_ptr_q] <= vaddr_i;
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: scoreboard bench for inst_buffer (DEPTH=8), honours IB_BYPASS_EN.
module tb_inst_buffer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] inst_i = '0, vaddr_i = '0;
    logic        ib_valid_i = 1'b0, id_ready_i = 1'b0;
    logic        ib_ready_o, id_valid_o;
    logic [31:0] inst_o, vaddr_o;
    logic [3:0]  count_o;

    int n_chk = 0, n_pass = 0;
    logic [63:0] sb [$];
    logic [31:0] pc = 32'h1c00_0000;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_i(inst_i), .vaddr_i(vaddr_i), .ib_valid_i(ib_valid_i), .ib_ready_o(ib_ready_o),
        .inst_o(inst_o), .vaddr_o(vaddr_o), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // One cycle: drive, check against the model, then advance past the edge
    task automatic cyc(input logic v, input logic r, input logic f, input logic [31:0] in);
        logic [63:0] e;
        bit byp, push, pop;
        int n;
        n = sb.size();
        ib_valid_i = v; id_ready_i = r; flush = f; vaddr_i = pc; inst_i = in;
        #1;
        byp = 0;
`ifdef IB_BYPASS_EN
        byp = n == 0 && v && !f;
`endif
        push = v && n != DEPTH && !f && !(byp && r);
        pop  = n != 0 && r && !f;
        chk("ready", 64'(ib_ready_o), 64'(n != DEPTH));
        chk("valid", 64'(id_valid_o), 64'(!f && (n != 0 || byp)));
        chk("count", 64'(count_o), 64'(n));
        if (byp) chk("bypass", {vaddr_o, inst_o}, {pc, in});
        else if (pop) begin
            e = sb.pop_front();
            chk("data", {vaddr_o, inst_o}, e);
        end
        if (push) sb.push_back({pc, in});
        if (push || (byp && r)) pc += 4;
        if (f) sb.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(id_valid_o), 64'd0);
        chk("rst_ready", 64'(ib_ready_o), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        // Fill
        for (int k = 0; k < DEPTH; k++) cyc(1, 0, 0, mk(pc));
        cyc(0, 0, 0, 0);
        chk("fill_vaddr", 64'(vaddr_o), 64'h1c00_0000);
        // Full plus pop: offered entry must be refused
        cyc(1, 1, 0, mk(pc));
        cyc(0, 0, 0, 0);
        // Streaming across pointer wrap
        for (int k = 0; k < 20; k++) cyc(1, 1, 0, mk(pc));
        // Down to 5, then flush with push and pop asserted
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 1, mk(pc));
        cyc(0, 0, 0, 0);
        // Empty push with decode ready
        cyc(1, 1, 0, 32'h0280_0000);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // Asynchronous reset at count 3
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, mk(pc));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_valid", 64'(id_valid_o), 64'd0);
        chk("arst_ready", 64'(ib_ready_o), 64'd1);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        // Random traffic with occasional flush
        for (int k = 0; k < 200; k++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, mk(pc));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of instruction entries; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  pipeline redirect (branch, exception, ertn); discards all buffered entries.
REQ-005 inst_i  input  32  instruction word from the fetch stage.
REQ-006 vaddr_i  input  32  PC of inst_i.
REQ-007 ib_valid_i  input  1  fetch stage offers inst_i/vaddr_i.
REQ-008 ib_ready_o  output  1  buffer accepts the offered entry this cycle.
REQ-009 inst_o  output  32  oldest instruction, to decode.
REQ-010 vaddr_o  output  32  PC of inst_o.
REQ-011 id_valid_o  output  1  inst_o/vaddr_o are valid.
REQ-012 id_ready_i  input  1  decode consumes the presented entry this cycle.
REQ-013 count_o  output  log2(DEPTH)+1  number of stored entries.

Function
REQ-014 Storage: circular FIFO of DEPTH entries of {vaddr, inst}; write pointer, read pointer, and count register.
REQ-015 Push occurs when ib_valid_i && ib_ready_o && !flush; the entry is written at the write pointer and the pointer advances by 1.
REQ-016 Pop occurs when id_valid_o && id_ready_i && !flush; the read pointer advances by 1.
REQ-017 Pointers wrap from DEPTH-1 to 0; count is never above DEPTH or below 0.
REQ-018 ib_ready_o = (count != DEPTH); it depends only on registered state, never on id_ready_i.
REQ-019 When full, a same-cycle pop does not enable a push; ib_ready_o stays 0 that cycle.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH: both pointers advance and count is unchanged.
REQ-021 id_valid_o = (count != 0), unless REQ-029 applies; inst_o/vaddr_o = entry at the read pointer.
REQ-022 Empty: id_valid_o = 0; inst_o/vaddr_o hold don't-care values that the bench does not check.
REQ-023 Order is strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-024 Flush: on the next edge, pointers and count go to 0; any push or pop in the flush cycle is ignored.
REQ-025 Flush cycle: id_valid_o is forced to 0 combinationally; ib_ready_o follows REQ-018.
REQ-026 Minimum latency from push to id_valid_o is 1 cycle (without REQ-029).

Reset
REQ-027 While reset = 0: pointers = 0, count = 0, id_valid_o = 0, ib_ready_o = 1, count_o = 0.
REQ-028 Reset asserted mid-operation discards all entries immediately; storage contents are not cleared.

Configuration
REQ-029 With macro IB_BYPASS_EN defined, when count = 0 and ib_valid_i && !flush:
- id_valid_o = 1 and inst_o/vaddr_o = inst_i/vaddr_i combinationally.
- If id_ready_i = 1, the entry is consumed with no write and no pointer change.
- Otherwise the entry is pushed normally.
REQ-030 Without IB_BYPASS_EN, no combinational path exists from inst_i/vaddr_i/ib_valid_i to any output; push-to-output latency is 1 cycle.

Verification
REQ-031 Fill: DEPTH=8, push PCs 0x1c000000+4k for k=0..7 with id_ready_i=0 -> count_o=8, ib_ready_o=0, id_valid_o=1, vaddr_o=0x1c000000.
REQ-032 Full plus pop: from full, ib_valid_i=1 and id_ready_i=1 -> next count_o=7, offered entry not accepted; following cycle ib_ready_o=1.
REQ-033 Streaming: continuous push and pop for 20 cycles -> vaddr_o sequence strictly +4, count_o constant, pointers wrap correctly.
REQ-034 Flush: count_o=5 with push and pop asserted in the flush cycle -> id_valid_o=0 that cycle; next count_o=0, id_valid_o=0.
REQ-035 Bypass: empty, push inst 0x02800000 with id_ready_i=1 -> with IB_BYPASS_EN, inst_o=0x02800000 same cycle and count_o stays 0; without it, id_valid_o=1 one cycle later and count_o=1.
REQ-036 Reset: assert reset asynchronously at count_o=3 -> count_o=0, id_valid_o=0, ib_ready_o=1 before the next edge.
